corerfd_freq_window_check: RTL and testbench

Frequency-window checker that sits directly downstream of the sample counter. It counts rising edges of a monitored event signal during each sample window, where the window is delimited by the counter's `timeout` and `last_sample_cnt` outputs. At each window close it latches the count and compares it against programmable low/high thresholds. A hysteretic lock state machine then reports whether the monitored frequency is in range.

---
 rtl/corerfd_freq_window_check.sv | 203 ++++++++++++++++++++
 tb/tb_corerfd_freq_window_check.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/corerfd_freq_window_check.sv
// corerfd_freq_window_check
// Counts rising edges of evt_in inside each sample window delimited by the
// sample counter's last_sample_cnt / timeout pulses. At each valid window close
// it publishes the count, compares it against inclusive thresholds and drives
// a hysteretic lock state machine (UNLOCKED -> ACQUIRE -> LOCKED).
module corerfd_freq_window_check #(
  parameter int CNT_W  = 16,
  parameter int HYST_N = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             timeout,
  input  logic             last_sample_cnt,
  input  logic             evt_in,
  input  logic [CNT_W-1:0] lo_thresh,
  input  logic [CNT_W-1:0] hi_thresh,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  output logic             in_range,
  output logic             overflow,
  output logic             lock,
  output logic             lock_lost
);

  localparam logic [CNT_W-1:0] ACC_MAX = {CNT_W{1'b1}};
  localparam logic [3:0]       HYST_L  = 4'(HYST_N);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  // Saturating increment; MSB of the result flags an increment attempted at
  // the saturation value (the accumulator itself never wraps).
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] a,
                                             input logic             inc);
    logic [CNT_W:0] res;
    if (!inc) begin
      res = {1'b0, a};
    end else if (a == ACC_MAX) begin
      res = {1'b1, a};
    end else begin
      res = {1'b0, a + CNT_W'(1)};
    end
    return res;
  endfunction

  logic             r_evt_q;
  logic [CNT_W-1:0] r_acc;
  logic             r_ovf;
  logic             r_armed;
  logic             r_first_win;
  state_t           r_state;
  logic [3:0]       r_good_cnt;

  logic             w_edge;
  logic             w_sat_now;
  logic [CNT_W-1:0] w_final;
  logic             w_ovf_now;
  logic             w_valid_to;
  logic             w_in_range_now;
  logic [3:0]       w_good_inc;

  // Edge detect, window-close count (including an edge in the timeout cycle),
  // timeout qualification and the threshold comparison.
  always_comb begin
    w_edge                = evt_in & ~r_evt_q;
    {w_sat_now, w_final}  = sat_inc(r_acc, w_edge);
    w_ovf_now             = r_ovf | w_sat_now;
    w_valid_to            = en & timeout & r_armed & ~r_first_win;
    w_in_range_now        = ~w_ovf_now & (lo_thresh <= w_final) & (w_final <= hi_thresh);
    w_good_inc            = r_good_cnt + 4'd1;
  end

  // Previous evt_in sample; held low while disabled so a high input at enable
  // counts as one edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_evt_q <= 1'b0;
    end else if (!en) begin
      r_evt_q <= 1'b0;
    end else begin
      r_evt_q <= evt_in;
    end
  end

  // Edge accumulator with sticky saturation flag; restarts after every timeout.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (!en || timeout) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_acc <= w_final;
      r_ovf <= w_ovf_now;
    end
  end

  // Window arming: a window is complete only if last_sample_cnt preceded the
  // timeout; the first window after reset or enable is always partial.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_armed     <= 1'b0;
      r_first_win <= 1'b1;
    end else begin
      if (timeout) begin
        r_armed <= 1'b0;
      end else if (last_sample_cnt) begin
        r_armed <= 1'b1;
      end else begin
        r_armed <= r_armed;
      end
      if (!en) begin
        r_first_win <= 1'b1;
      end else if (timeout) begin
        r_first_win <= 1'b0;
      end else begin
        r_first_win <= r_first_win;
      end
    end
  end

  // Result registers: updated only on a valid window close, held otherwise
  // (including while disabled).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_out   <= '0;
      count_valid <= 1'b0;
      in_range    <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      count_valid <= w_valid_to;
      if (w_valid_to) begin
        count_out <= w_final;
        overflow  <= w_ovf_now;
        in_range  <= w_in_range_now;
      end
    end
  end

  // Hysteretic lock FSM with registered lock / lock_lost; advances only on
  // valid timeouts and is forced to UNLOCKED (silently) while disabled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_UNLOCKED;
      r_good_cnt <= 4'd0;
      lock       <= 1'b0;
      lock_lost  <= 1'b0;
    end else if (!en) begin
      r_state    <= ST_UNLOCKED;
      r_good_cnt <= 4'd0;
      lock       <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      lock_lost <= 1'b0;
      if (w_valid_to) begin
        case (r_state)
          ST_UNLOCKED: begin
            if (w_in_range_now) begin
              r_good_cnt <= 4'd1;
              if (HYST_L == 4'd1) begin
                r_state <= ST_LOCKED;
                lock    <= 1'b1;
              end else begin
                r_state <= ST_ACQUIRE;
              end
            end
          end
          ST_ACQUIRE: begin
            if (w_in_range_now) begin
              r_good_cnt <= w_good_inc;
              if (w_good_inc == HYST_L) begin
                r_state <= ST_LOCKED;
                lock    <= 1'b1;
              end
            end else begin
              r_state    <= ST_UNLOCKED;
              r_good_cnt <= 4'd0;
            end
          end
          ST_LOCKED: begin
            if (!w_in_range_now) begin
              r_state    <= ST_UNLOCKED;
              r_good_cnt <= 4'd0;
              lock       <= 1'b0;
              lock_lost  <= 1'b1;
            end
          end
          default: begin
            r_state    <= ST_UNLOCKED;
            r_good_cnt <= 4'd0;
            lock       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_corerfd_freq_window_check.sv
// Bench for corerfd_freq_window_check: two instances (16-bit/HYST 3 and
// 4-bit/HYST 1) share one stimulus stream. A window-level reference model
// pushes expected window results into queues; a negedge monitor pops them.
module tb_corerfd_freq_window_check;

  logic        clk = 1'b0;
  logic        rstn, en, timeout, lsc, evt;
  logic [15:0] lo0, hi0, co0;
  logic [3:0]  lo1, hi1, co1;
  logic        cv0, ir0, ov0, lk0, ll0;
  logic        cv1, ir1, ov1, lk1, ll1;

  always #5 clk = ~clk;

  corerfd_freq_window_check #(.CNT_W(16), .HYST_N(3)) u_dut0 (
    .clk(clk), .rstn(rstn), .en(en), .timeout(timeout), .last_sample_cnt(lsc),
    .evt_in(evt), .lo_thresh(lo0), .hi_thresh(hi0), .count_out(co0),
    .count_valid(cv0), .in_range(ir0), .overflow(ov0), .lock(lk0), .lock_lost(ll0));

  corerfd_freq_window_check #(.CNT_W(4), .HYST_N(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .en(en), .timeout(timeout), .last_sample_cnt(lsc),
    .evt_in(evt), .lo_thresh(lo1), .hi_thresh(hi1), .count_out(co1),
    .count_valid(cv1), .in_range(ir1), .overflow(ov1), .lock(lk1), .lock_lost(ll1));

  typedef struct { int unsigned cnt; bit ovf; bit inr; } exp_t;

  exp_t        q0[$], q1[$];
  int          checks = 0, failures = 0;
  bit          mon_on = 1'b0;

  // reference model state (window level)
  int unsigned m_cnt;
  bit          m_prev, m_armed, m_first;
  int          m_good[2];
  bit          m_locked[2];
  bit          p_valid;
  exp_t        p_exp[2];
  bit          p_lost[2];
  bit          vis_lock[2], vis_lost[2];
  int unsigned last_cnt[2];
  bit          last_ovf[2], last_inr[2];
  int unsigned mx[2]  = '{65535, 15};
  int          hyst[2] = '{3, 1};

  // driver state
  bit          cur_evt;
  logic [15:0] n_lo0, n_hi0, t_lo0, t_hi0;
  logic [3:0]  n_lo1, n_hi1, t_lo1, t_hi1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  // Evaluate the spec rules for the cycle whose inputs were just applied.
  task automatic model_eval();
    bit          e;
    int unsigned fin, lo, hi;
    bit          ovf, inr;
    if (!en) begin
      m_prev = 1'b0; m_cnt = 0; m_first = 1'b1;
      for (int k = 0; k < 2; k++) begin m_good[k] = 0; m_locked[k] = 1'b0; end
      if (timeout) m_armed = 1'b0; else if (lsc) m_armed = 1'b1;
      return;
    end
    e = evt && !m_prev;
    m_prev = evt;
    if (e) m_cnt++;
    if (timeout) begin
      if (m_armed && !m_first) begin
        for (int k = 0; k < 2; k++) begin
          ovf = (m_cnt > mx[k]);
          fin = ovf ? mx[k] : m_cnt;
          lo  = (k == 0) ? int'(lo0) : int'(lo1);
          hi  = (k == 0) ? int'(hi0) : int'(hi1);
          inr = !ovf && (lo <= fin) && (fin <= hi);
          p_exp[k].cnt = fin; p_exp[k].ovf = ovf; p_exp[k].inr = inr;
          if (inr) begin
            if (!m_locked[k]) begin
              m_good[k]++;
              if (m_good[k] >= hyst[k]) m_locked[k] = 1'b1;
            end
          end else begin
            p_lost[k]   = m_locked[k];
            m_locked[k] = 1'b0;
            m_good[k]   = 0;
          end
        end
        p_valid = 1'b1;
      end
      m_cnt = 0; m_first = 1'b0; m_armed = 1'b0;
    end else if (lsc) begin
      m_armed = 1'b1;
    end
  endtask

  // Results of the cycle that just ended become visible now.
  task automatic commit();
    if (p_valid) begin q0.push_back(p_exp[0]); q1.push_back(p_exp[1]); end
    for (int k = 0; k < 2; k++) begin
      vis_lock[k] = m_locked[k];
      vis_lost[k] = p_lost[k];
      p_lost[k]   = 1'b0;
    end
    p_valid = 1'b0;
  endtask

  task automatic step(input bit e, input bit to, input bit ls, input bit ev);
    @(posedge clk); #1;
    commit();
    en = e; timeout = to; lsc = ls; evt = ev;
    lo0 = n_lo0; hi0 = n_hi0; lo1 = n_lo1; hi1 = n_hi1;
    model_eval();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    commit();
    rstn = 1'b0;
    mon_on = 1'b1;
    q0.delete(); q1.delete();
    for (int k = 0; k < 2; k++) begin
      vis_lock[k] = 1'b0; vis_lost[k] = 1'b0; p_lost[k] = 1'b0;
      last_cnt[k] = 0; last_ovf[k] = 1'b0; last_inr[k] = 1'b0;
      m_good[k] = 0; m_locked[k] = 1'b0;
    end
    m_cnt = 0; m_prev = 1'b0; m_armed = 1'b0; m_first = 1'b1; p_valid = 1'b0;
    en = 1'b0; timeout = 1'b0; lsc = 1'b0; evt = 1'b0; cur_evt = 1'b0;
    #2;
    chk("rst_count_out0", 32'(co0), 32'd0);
    chk("rst_count_valid0", 32'(cv0), 32'd0);
    chk("rst_in_range0", 32'(ir0), 32'd0);
    chk("rst_overflow0", 32'(ov0), 32'd0);
    chk("rst_lock0", 32'(lk0), 32'd0);
    chk("rst_count_out1", 32'(co1), 32'd0);
    chk("rst_lock1", 32'(lk1), 32'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // One window of len cycles with n_edges rising edges; last_sample_cnt in the
  // second-to-last cycle when use_lsc, timeout in the last cycle. late pushes
  // the edges to the end so the final edge lands in the timeout cycle.
  task automatic gen_window(input int len, input int n_edges, input bit use_lsc,
                            input bit late, input int drop_at, input bit scramble);
    int rem;
    int left;
    rem = n_edges;
    for (int i = 0; i < len; i++) begin
      left = len - i;
      if (cur_evt) begin
        if (rem > 0) cur_evt = 1'b0;
        else         cur_evt = 1'($urandom_range(0, 1));
      end else if (rem > 0) begin
        if (left <= 2 * rem - 1 || (!late && $urandom_range(0, 1) == 1)) begin
          cur_evt = 1'b1;
          rem--;
        end
      end
      if (scramble && i < len - 1) begin
        n_lo0 = 16'($urandom); n_hi0 = 16'($urandom);
        n_lo1 = 4'($urandom);  n_hi1 = 4'($urandom);
      end else begin
        n_lo0 = t_lo0; n_hi0 = t_hi0; n_lo1 = t_lo1; n_hi1 = t_hi1;
      end
      step(i != drop_at, i == len - 1, use_lsc && (i == len - 2), cur_evt);
    end
  endtask

  task automatic mon_inst(input int k, input logic [15:0] co, input logic cv,
                          input logic ir, input logic ov, input logic lk, input logic ll);
    exp_t e;
    bit   have;
    have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
    chk($sformatf("count_valid%0d", k), 32'(cv), 32'(have));
    if (have) begin
      if (k == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      last_cnt[k] = e.cnt; last_ovf[k] = e.ovf; last_inr[k] = e.inr;
    end
    chk($sformatf("count_out%0d", k), 32'(co), last_cnt[k]);
    chk($sformatf("overflow%0d", k), 32'(ov), 32'(last_ovf[k]));
    chk($sformatf("in_range%0d", k), 32'(ir), 32'(last_inr[k]));
    chk($sformatf("lock%0d", k), 32'(lk), 32'(vis_lock[k]));
    chk($sformatf("lock_lost%0d", k), 32'(ll), 32'(vis_lost[k]));
  endtask

  // Monitor: compare every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        mon_inst(0, co0, cv0, ir0, ov0, lk0, ll0);
        mon_inst(1, {12'd0, co1}, cv1, ir1, ov1, lk1, ll1);
      end
    end
  end

  task automatic run_random();
    int len, ne, dr, a;
    bit ul, lt;
    for (int w = 0; w < 40; w++) begin
      len = $urandom_range(8, 80);
      ne  = $urandom_range(0, (len - 2) / 2);
      ul  = ($urandom_range(0, 9) != 0);
      lt  = ($urandom_range(0, 3) == 0);
      dr  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len - 1) : -1;
      a   = ne - $urandom_range(0, 2);
      t_lo0 = ($urandom_range(0, 1) == 1) ? 16'((a < 0) ? 0 : a) : 16'($urandom_range(0, 40));
      t_hi0 = ($urandom_range(0, 1) == 1) ? 16'(ne + $urandom_range(0, 2)) : 16'($urandom_range(0, 40));
      t_lo1 = 4'($urandom_range(0, 15));
      t_hi1 = 4'($urandom_range(0, 15));
      gen_window(len, ne, ul, lt, dr, 1'b1);
    end
  endtask

  initial begin
    rstn = 1'b1; en = 1'b0; timeout = 1'b0; lsc = 1'b0; evt = 1'b0; cur_evt = 1'b0;
    lo0 = 16'd0; hi0 = 16'd0; lo1 = 4'd0; hi1 = 4'd0;
    n_lo0 = 16'd0; n_hi0 = 16'd0; n_lo1 = 4'd0; n_hi1 = 4'd0;
    p_valid = 1'b0;
    do_reset();

    // nominal acquisition: first window discarded, lock on third valid window
    t_lo0 = 16'd95; t_hi0 = 16'd105; t_lo1 = 4'd0; t_hi1 = 4'd15;
    repeat (5) gen_window(230, 100, 1'b1, 1'b0, -1, 1'b0);
    // out-of-range window drops lock, next good window only re-enters ACQUIRE
    gen_window(240, 110, 1'b1, 1'b0, -1, 1'b0);
    gen_window(230, 100, 1'b1, 1'b0, -1, 1'b0);
    // edge coincident with timeout, then a fresh window
    gen_window(230, 100, 1'b1, 1'b1, -1, 1'b0);
    gen_window(230, 100, 1'b1, 1'b0, -1, 1'b0);
    // narrow accumulator: saturation and exact full-scale count
    gen_window(60, 20, 1'b1, 1'b0, -1, 1'b0);
    gen_window(40, 15, 1'b1, 1'b0, -1, 1'b0);
    // inverted thresholds never in range
    t_lo1 = 4'd9; t_hi1 = 4'd8; t_lo0 = 16'd9; t_hi0 = 16'd8;
    gen_window(40, 8, 1'b1, 1'b0, -1, 1'b0);
    // timeouts without last_sample_cnt, including back-to-back
    t_lo0 = 16'd95; t_hi0 = 16'd105; t_lo1 = 4'd0; t_hi1 = 4'd15;
    gen_window(50, 10, 1'b0, 1'b0, -1, 1'b0);
    gen_window(1, 0, 1'b0, 1'b0, -1, 1'b0);
    gen_window(30, 10, 1'b1, 1'b0, -1, 1'b0);
    // lock, then drop enable for one cycle; relock needs fresh windows
    repeat (3) gen_window(230, 100, 1'b1, 1'b0, -1, 1'b0);
    gen_window(230, 100, 1'b1, 1'b0, 50, 1'b0);
    repeat (3) gen_window(230, 100, 1'b1, 1'b0, -1, 1'b0);
    // en falling in the timeout cycle
    gen_window(230, 100, 1'b1, 1'b0, 229, 1'b0);
    // reset mid-window
    repeat (20) begin cur_evt = ~cur_evt; step(1'b1, 1'b0, 1'b0, cur_evt); end
    do_reset();
    repeat (2) gen_window(230, 100, 1'b1, 1'b0, -1, 1'b0);

    run_random();
    repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
